// File: rtl/alu_pkg.sv
// Shared ALU op-codes and sequencer state encoding.
// The multicycle control FSM imports these as well.
package alu_pkg;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRL  = 3'b110;
  localparam logic [2:0] ALU_ZERO = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational datapath ALU. Shifts move by exactly one bit and are logical.
module alu_op_sequencer_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_sel,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_sel)
      ALU_ADD: o_y = i_a + i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      ALU_SLL: o_y = {i_a[WIDTH-2:0], 1'b0};
      ALU_SRL: o_y = {1'b0, i_a[WIDTH-1:1]};
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Start/done front end for the ALU: single-cycle ops finish in one cycle,
// variable-distance shifts iterate the ALU's shift-by-1 through an accumulator.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_opnd_a,
  input  logic [WIDTH-1:0]   i_opnd_b,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_result
);

  seq_state_t         r_state, w_state_next;
  logic [WIDTH-1:0]   r_result, w_result_next;
  logic [WIDTH-1:0]   r_acc, w_acc_next;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]         r_op, w_op_next;

  logic               w_in_shift;
  logic [WIDTH-1:0]   w_alu_a;
  logic [WIDTH-1:0]   w_alu_y;
  logic [2:0]         w_alu_sel;

  // While shifting, the ALU sees only latched values so live inputs can't disturb it.
  assign w_in_shift = (r_state == SHIFT);
  assign w_alu_a    = w_in_shift ? r_acc : i_opnd_a;
  assign w_alu_sel  = w_in_shift ? r_op  : i_op;

  alu_op_sequencer_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a   (w_alu_a),
    .i_b   (i_opnd_b),
    .i_sel (w_alu_sel),
    .o_y   (w_alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= ALU_NOP;
    end else begin
      r_state  <= w_state_next;
      r_result <= w_result_next;
      r_acc    <= w_acc_next;
      r_cnt    <= w_cnt_next;
      r_op     <= w_op_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_result_next = r_result;
    w_acc_next    = r_acc;
    w_cnt_next    = r_cnt;
    w_op_next     = r_op;
    case (r_state)
      SHIFT: begin
        w_acc_next = w_alu_y;
        w_cnt_next = r_cnt - SHAMT_W'(1);
        if (r_cnt == SHAMT_W'(1)) begin
          w_result_next = w_alu_y;
          w_state_next  = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a launch, giving back-to-back issue.
        if (i_start) begin
          if (!is_shift_op(i_op)) begin
            w_result_next = w_alu_y;
            w_state_next  = DONE;
          end else if (i_shamt == '0) begin
            w_result_next = i_opnd_a;
            w_state_next  = DONE;
          end else begin
            w_acc_next   = i_opnd_a;
            w_cnt_next   = i_shamt;
            w_op_next    = i_op;
            w_state_next = SHIFT;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
    endcase
  end

  assign o_ready  = !w_in_shift;
  assign o_busy   = w_in_shift;
  assign o_done   = (r_state == DONE);
  assign o_result = r_result;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: directed cases plus random ops against an arithmetic model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_op = 3'b000;
  logic [31:0] i_opnd_a = '0;
  logic [31:0] i_opnd_b = '0;
  logic [4:0]  i_shamt = '0;
  logic        o_ready, o_busy, o_done;
  logic [31:0] o_result;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_opnd_a (i_opnd_a),
    .i_opnd_b (i_opnd_b),
    .i_shamt  (i_shamt),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the op's meaning written directly as arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return (int'(sh) >= 32) ? 32'h0 : (a << sh);
      3'b110:  return (int'(sh) >= 32) ? 32'h0 : (a >> sh);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [4:0] sh);
    if ((op == 3'b101 || op == 3'b110) && sh != 0) return int'(sh) + 1;
    return 1;
  endfunction

  // Issue one op from a negedge with the block ready; returns on the negedge after done.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    int lat;
    logic [31:0] exp;
    exp = model_result(op, a, b, sh);
    check({tag, "_ready"}, {31'b0, o_ready}, 32'd1);
    i_start = 1'b1; i_op = op; i_opnd_a = a; i_opnd_b = b; i_shamt = sh;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_op = 3'($urandom); i_opnd_a = $urandom; i_opnd_b = $urandom; i_shamt = 5'($urandom);
    lat = 1;
    @(negedge clk);
    while (o_done !== 1'b1 && lat < 100) begin
      if (o_busy !== 1'b1 || o_ready !== 1'b0)
        check({tag, "_busy_wait"}, {30'b0, o_busy, o_ready}, 32'd2);
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, {31'b0, o_done}, 32'd1);
    check({tag, "_lat"}, lat, model_latency(op, sh));
    check({tag, "_result"}, o_result, exp);
    check({tag, "_busy_in_done"}, {31'b0, o_busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, o_done}, 32'd0);
    check({tag, "_hold"}, o_result, exp);
  endtask

  initial begin
    logic [2:0]  b2b_op [4];
    logic [31:0] b2b_a  [4];
    logic [31:0] b2b_b  [4];
    logic [31:0] orig_a;
    int          dones;
    int          lat;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", o_result, 32'h0);
    check("rst_flags", {29'b0, o_ready, o_busy, o_done}, 32'h4);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_flags", {29'b0, o_ready, o_busy, o_done}, 32'h4);

    // Single-cycle ops
    do_op("add_wrap", 3'b001, 32'hFFFFFFFF, 32'h1, 5'd0);
    do_op("and", 3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    do_op("or",  3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    do_op("xor", 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    do_op("nop", 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 5'd3);
    do_op("zero", 3'b111, 32'hDEADBEEF, 32'hDEADBEEF, 5'd3);

    // Shifts
    do_op("sll31", 3'b101, 32'h1, 32'h0, 5'd31);
    do_op("sll0", 3'b101, 32'h1234, 32'h5, 5'd0);
    do_op("srl4", 3'b110, 32'h80000000, 32'h0, 5'd4);
    do_op("srl31", 3'b110, 32'hFFFFFFFF, 32'h0, 5'd31);

    // Back-to-back single-cycle ops: four consecutive done pulses
    b2b_op = '{3'b001, 3'b010, 3'b011, 3'b100};
    b2b_a  = '{32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
    b2b_b  = '{32'h1, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
    for (int k = 0; k < 4; k++) begin
      i_start = 1'b1; i_op = b2b_op[k]; i_opnd_a = b2b_a[k]; i_opnd_b = b2b_b[k]; i_shamt = 5'd0;
      @(negedge clk);
      check($sformatf("b2b%0d_done", k), {31'b0, o_done}, 32'd1);
      check($sformatf("b2b%0d_result", k), o_result, model_result(b2b_op[k], b2b_a[k], b2b_b[k], 5'd0));
    end
    i_start = 1'b0;
    @(negedge clk);
    check("b2b_end_done", {31'b0, o_done}, 32'd0);

    // Start ignored during SRL by 8; operands changed mid-shift
    orig_a = 32'hA5C3_0F81;
    i_start = 1'b1; i_op = 3'b110; i_opnd_a = orig_a; i_opnd_b = 32'h0; i_shamt = 5'd8;
    @(posedge clk); #1;
    i_start = 1'b0;
    dones = 0;
    lat = 1;
    @(negedge clk);
    for (int c = 1; c < 20; c++) begin
      if (c == 3) begin
        i_start = 1'b1; i_op = 3'b001; i_opnd_a = 32'h1111_1111; i_opnd_b = 32'h2;
      end else begin
        i_start = 1'b0;
      end
      if (o_done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          check("ign_lat", c, 9);
          check("ign_result", o_result, orig_a >> 8);
        end
      end
      @(negedge clk);
    end
    check("ign_one_done", dones, 1);

    // Start in the DONE cycle of a shift: no bubble
    i_start = 1'b1; i_op = 3'b101; i_opnd_a = 32'h1; i_opnd_b = 32'h0; i_shamt = 5'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 1;
    @(negedge clk);
    while (o_done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("chain_sll_lat", lat, 4);
    check("chain_sll_result", o_result, 32'h8);
    i_start = 1'b1; i_op = 3'b001; i_opnd_a = 32'd5; i_opnd_b = 32'd6;
    @(negedge clk);
    i_start = 1'b0;
    check("chain_add_done", {31'b0, o_done}, 32'd1);
    check("chain_add_result", o_result, 32'd11);
    @(negedge clk);

    // Asynchronous reset in the middle of a long shift
    i_start = 1'b1; i_op = 3'b101; i_opnd_a = 32'h3; i_opnd_b = 32'h0; i_shamt = 5'd20;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_busy", {31'b0, o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_flags", {29'b0, o_ready, o_busy, o_done}, 32'h4);
    check("abort_result", o_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_busy === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);

    // Randomized ops against the model
    for (int t = 0; t < 40; t++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [4:0]  rsh;
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      rsh = 5'($urandom_range(0, 12));
      do_op($sformatf("rnd%0d_op%0d", t, rop), rop, ra, rb, rsh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global invariant; also bounds the run in case something hangs.
  always @(negedge clk) begin
    if (rst_n && o_done === 1'b1 && o_busy === 1'b1) check("done_and_busy", 32'd1, 32'd0);
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
